multicycle_control_fsm: RTL
===========================

# multicycle_control_fsm

Control state machine for the multicycle RV32I datapath, succeeding the single-cycle main decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states over one shared memory port and one ALU. Generalised to parametrised opcode/ALU-op/immediate-select widths and adds jal/lui support. It also adds a memory-ready wait handshake, illegal-opcode reporting and an instruction-retired pulse.

## Interface
- OP_WIDTH, 7, opcode width
- ALU_OP_WIDTH, 2, ALUOp width to ALU decoder
- IMM_SRC_WIDTH, 3, immediate-select width (must be ≥3)
- STATE_WIDTH, 4, debug state bus width
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- op  in  OP_WIDTH  opcode of the instruction register
- MemReady  in  1  memory completes the current access this cycle
- PCUpdate  out  1  PC load enable
- IRWrite  out  1  instruction register / OldPC load enable
- RegWrite  out  1  register file write enable
- MemWrite  out  1  data write strobe
- MemReq  out  1  memory access request
- Branch  out  1  conditional branch qualifier
- AdrSrc  out  1  memory address: 0=PC, 1=ALUOut
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=rs1 reg, 11=zero
- ALUSrcB  out  2  00=rs2 reg, 01=ImmExt, 10=constant 4
- ResultSrc  out  2  00=ALUOut, 01=read data, 10=ALUResult
- ALUOp  out  ALU_OP_WIDTH  00=add, 01=branch compare, 10=funct-decoded
- ImmSrc  out  IMM_SRC_WIDTH  000=I, 001=S, 010=B, 011=J, 100=U
- IllegalOp  out  1  one-cycle pulse, unsupported opcode
- InstrRetired  out  1  one-cycle pulse, instruction completed
- State  out  STATE_WIDTH  current state encoding (debug)

## Operation
- States/codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, ALUWB 7, EXECI 8, JAL 9, BRANCH 10, LUI 11. Codes 12-15 → FETCH next cycle.
- Outputs default 0 every state unless listed. Outputs are Moore, except the MemReady-gated signals noted.
- FETCH: MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite=PCUpdate=MemReady. Stays in FETCH until MemReady, then → DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch/jump target).
  - Opcode routing: 0000011/0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1100011 → BRANCH; 1101111 → JAL; 0110111 → LUI.
  - Any other opcode: IllegalOp=1, → FETCH.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. → MEMREAD if op=0000011, else → MEMWRITE.
- MEMREAD: MemReq=1, AdrSrc=1. Waits for MemReady, then → MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. → FETCH.
- MEMWRITE: MemReq=1, AdrSrc=1. MemWrite=MemReady. Waits for MemReady, then → FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. → ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. → ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. → FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. → ALUWB.
- LUI: ALUSrcA=11, ALUSrcB=01, ALUOp=00. → ALUWB.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. → FETCH.
- InstrRetired=1 on every transition into FETCH, except from DECODE (illegal opcode) and from invalid state codes.
- ImmSrc is combinational from op in all states:
  - 0000011/0010011 → 000
  - 0100011 → 001
  - 1100011 → 010
  - 1101111 → 011
  - 0110111 → 100
  - else → 000
- ALUOp is zero-extended to ALU_OP_WIDTH. ImmSrc is zero-extended to IMM_SRC_WIDTH.

## Timing
- Reset: while rst=1, all 1-bit outputs are 0 and State=0. Multi-bit selects show FETCH values with enables forced 0. First cycle after rst falls is FETCH.
- Reset mid-instruction (any state, including a wait) aborts it: no RegWrite/MemWrite/InstrRetired follows. Next state is FETCH.
- Zero-wait cycle counts: lw 5, sw 4, R 4, I 4, jal 4, lui 4, branch 3, illegal 2.
- Each low-MemReady cycle in FETCH/MEMREAD/MEMWRITE adds one cycle. Outputs are held stable during waits.
- MemReady outside FETCH/MEMREAD/MEMWRITE is ignored.
- op must be stable from DECODE to retirement; the IR is only written in FETCH.

## Test plan
- Reset: rst=1 for 3 cycles with MemReady=1 → State=0, PCUpdate=IRWrite=RegWrite=MemWrite=0. Release → FETCH, IRWrite=1 in the first cycle.
- lw (op=0000011), MemReady=1 → States 0,1,2,3,4,0. RegWrite=1 only in state 4 with ResultSrc=01. InstrRetired pulses once. ImmSrc=000.
- sw (op=0100011), MemReady low for 2 cycles in MEMWRITE → MemWrite=0,0,1 across the 3 MEMWRITE cycles. Sequence 0,1,2,5,5,5,0. RegWrite never asserted.
- beq (op=1100011) → 0,1,10,0 with Branch=1, ALUOp=01, ImmSrc=010. jal (1101111) → 0,1,9,7,0 with PCUpdate=1 in state 9 and RegWrite=1 in state 7.
- op=1111111 → 0,1,0 with IllegalOp=1 in DECODE, InstrRetired=0, no RegWrite/MemWrite.
- rst asserted while in MEMREAD waiting → next State=0, no MEMWB visited. After release, a lui (0110111) completes 0,1,11,7,0 with ALUSrcA=11, ImmSrc=100.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared memory port and ALU, with memory-ready waits and retire/illegal pulses.
module multicycle_control_fsm #(
    parameter int OP_WIDTH      = 7,
    parameter int ALU_OP_WIDTH  = 2,
    parameter int IMM_SRC_WIDTH = 3,
    parameter int STATE_WIDTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [OP_WIDTH-1:0]      op,
    input  logic                     MemReady,
    output logic                     PCUpdate,
    output logic                     IRWrite,
    output logic                     RegWrite,
    output logic                     MemWrite,
    output logic                     MemReq,
    output logic                     Branch,
    output logic                     AdrSrc,
    output logic [1:0]               ALUSrcA,
    output logic [1:0]               ALUSrcB,
    output logic [1:0]               ResultSrc,
    output logic [ALU_OP_WIDTH-1:0]  ALUOp,
    output logic [IMM_SRC_WIDTH-1:0] ImmSrc,
    output logic                     IllegalOp,
    output logic                     InstrRetired,
    output logic [STATE_WIDTH-1:0]   State
);

    localparam logic [OP_WIDTH-1:0] OP_LOAD   = OP_WIDTH'(7'b0000011);
    localparam logic [OP_WIDTH-1:0] OP_STORE  = OP_WIDTH'(7'b0100011);
    localparam logic [OP_WIDTH-1:0] OP_RTYPE  = OP_WIDTH'(7'b0110011);
    localparam logic [OP_WIDTH-1:0] OP_ITYPE  = OP_WIDTH'(7'b0010011);
    localparam logic [OP_WIDTH-1:0] OP_BRANCH = OP_WIDTH'(7'b1100011);
    localparam logic [OP_WIDTH-1:0] OP_JAL    = OP_WIDTH'(7'b1101111);
    localparam logic [OP_WIDTH-1:0] OP_LUI    = OP_WIDTH'(7'b0110111);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10,
        S_LUI      = 4'd11
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] alu_op;
    logic [2:0] imm_src;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        PCUpdate     = 1'b0;
        IRWrite      = 1'b0;
        RegWrite     = 1'b0;
        MemWrite     = 1'b0;
        MemReq       = 1'b0;
        Branch       = 1'b0;
        AdrSrc       = 1'b0;
        IllegalOp    = 1'b0;
        InstrRetired = 1'b0;
        ALUSrcA      = 2'b00;
        ALUSrcB      = 2'b00;
        ResultSrc    = 2'b00;
        alu_op       = 2'b00;
        case (state_q)
            S_FETCH: begin
                MemReq    = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = MemReady;
                PCUpdate  = MemReady;
                if (MemReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_LUI:            state_d = S_LUI;
                    default: begin
                        IllegalOp = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                MemReq = 1'b1;
                AdrSrc = 1'b1;
                if (MemReady) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc    = 2'b01;
                RegWrite     = 1'b1;
                InstrRetired = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
                MemReq       = 1'b1;
                AdrSrc       = 1'b1;
                MemWrite     = MemReady;
                InstrRetired = MemReady;
                if (MemReady) state_d = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite     = 1'b1;
                InstrRetired = 1'b1;
                state_d      = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                PCUpdate = 1'b1;
                state_d  = S_ALUWB;
            end
            S_LUI: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
                state_d = S_ALUWB;
            end
            S_BRANCH: begin
                ALUSrcA      = 2'b10;
                alu_op       = 2'b01;
                Branch       = 1'b1;
                InstrRetired = 1'b1;
                state_d      = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        // Reset aborts whatever is in flight: no write or retire may escape.
        if (rst) begin
            state_d      = S_FETCH;
            PCUpdate     = 1'b0;
            IRWrite      = 1'b0;
            RegWrite     = 1'b0;
            MemWrite     = 1'b0;
            MemReq       = 1'b0;
            Branch       = 1'b0;
            AdrSrc       = 1'b0;
            IllegalOp    = 1'b0;
            InstrRetired = 1'b0;
            ALUSrcA      = 2'b00;
            ALUSrcB      = 2'b10;
            ResultSrc    = 2'b10;
            alu_op       = 2'b00;
        end
    end

    always_comb begin
        imm_src = 3'b000;
        case (op)
            OP_STORE:  imm_src = 3'b001;
            OP_BRANCH: imm_src = 3'b010;
            OP_JAL:    imm_src = 3'b011;
            OP_LUI:    imm_src = 3'b100;
            default:   imm_src = 3'b000;
        endcase
    end

    assign ALUOp  = ALU_OP_WIDTH'(alu_op);
    assign ImmSrc = IMM_SRC_WIDTH'(imm_src);
    assign State  = rst ? '0 : STATE_WIDTH'(state_q);

endmodule
